// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the 8-bit datapath: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and selects, and counts retired instructions.
module mc_control_fsm #(
  parameter int CNT_W = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic [1:0]       cond,
  input  logic             z_flag,
  input  logic             n_flag,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_req,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ctrl,
  output logic [1:0]       result_src,
  output logic [1:0]       len_sel,
  output logic             flag_write,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ORR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_B    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(8);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [1:0]       cond_q, cond_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  function automatic logic branch_taken(input logic [1:0] c, input logic z, input logic n);
    case (c)
      2'b00:   return 1'b1;
      2'b01:   return z;
      2'b10:   return !z;
      default: return n;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      cond_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cond_q    <= cond_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cond_d    = cond_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d   = op;
        cond_d = cond;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: state_d = S_EXEC_R;
          OP_ADDI:                        state_d = S_EXEC_I;
          OP_LDR, OP_STR:                 state_d = S_MEM_ADDR;
          OP_B:                           state_d = S_BRANCH;
          OP_HALT:                        state_d = S_HALT;
          default:                        state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (op_q == OP_LDR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d   = S_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      S_HALT:    state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset overrides the state decode so that nothing is enabled during the reset cycle.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = 2'b00;
    result_src = 2'b00;
    len_sel    = 2'b00;
    flag_write = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    retired    = retired_q;
    state_dbg  = state_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b01;
        alu_ctrl   = op_q[1:0];
        flag_write = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        len_sel    = 2'b10;
        flag_write = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        len_sel   = 2'b01;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        len_sel    = 2'b11;
        result_src = 2'b10;
        pc_write   = branch_taken(cond_q, z_flag, n_flag);
      end
      S_HALT:    halted  = 1'b1;
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = 2'b00;
      result_src = 2'b00;
      len_sel    = 2'b00;
      flag_write = 1'b0;
      halted     = 1'b0;
      illegal    = 1'b0;
      retired    = '0;
      state_dbg  = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios with literal checks plus random traffic
// compared every cycle against an instruction-route reference model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op = 4'd0;
  logic [1:0] cond = 2'd0;
  logic       z_flag = 1'b0, n_flag = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_req, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_ctrl, result_src, len_sel;
  logic       flag_write, halted, illegal;
  logic [7:0] retired;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  mc_control_fsm #(.CNT_W(8), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .cond(cond), .z_flag(z_flag), .n_flag(n_flag),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_req(mem_req), .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src), .len_sel(len_sel),
    .flag_write(flag_write), .halted(halted), .illegal(illegal), .retired(retired),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [30:0] dvec;
  assign dvec = {pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, alu_src_a,
                 alu_src_b, alu_ctrl, result_src, len_sel, flag_write, halted, illegal,
                 retired, state_dbg};

  // Reference model: each instruction is a route of phases after DECODE; it retires when
  // its route runs out, memory phases stall on mem_ready, HALT/ILLEGAL trap forever.
  int       m_ph = 0;
  int       m_pos = 0;
  int       m_route[$];
  logic [3:0] m_op = 0;
  logic [1:0] m_cond = 0;
  logic [7:0] m_ret = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_pos = 0; m_ret = 0; m_op = 0; m_cond = 0;
    end else if (m_ph == 0) begin
      if (mem_ready) m_ph = 1;
    end else if (m_ph == 1) begin
      m_op = op; m_cond = cond;
      if (op <= 3)       m_route = '{2, 4};
      else if (op == 4)  m_route = '{3, 4};
      else if (op == 5)  m_route = '{5, 6, 7};
      else if (op == 6)  m_route = '{5, 8};
      else if (op == 7)  m_route = '{9};
      else if (op == 8)  m_route = '{10};
      else               m_route = '{11};
      m_pos = 0;
      m_ph  = m_route[0];
    end else if (m_ph == 10 || m_ph == 11) begin
      m_ph = m_ph;
    end else if ((m_ph == 6 || m_ph == 8) && !mem_ready) begin
      m_ph = m_ph;
    end else begin
      m_pos++;
      if (m_pos >= m_route.size()) begin
        m_ret = m_ret + 8'd1;
        m_ph  = 0;
      end else begin
        m_ph = m_route[m_pos];
      end
    end
  end

  function automatic logic [30:0] expect_out(int ph, logic [3:0] o, logic [1:0] c, logic z,
                                             logic n, logic mr, logic rst, logic [7:0] ret);
    logic pc, ir, adr, mreq, mw, rw, fw, hl, il;
    logic [1:0] sa, sb, ctl, res, len;
    {pc, ir, adr, mreq, mw, rw, fw, hl, il} = '0;
    {sa, sb, ctl, res, len} = '0;
    case (ph)
      0:  begin mreq = 1; if (mr) begin ir = 1; pc = 1; sb = 2; res = 2; end end
      2:  begin sa = 1; ctl = o[1:0]; fw = 1; end
      3:  begin sa = 1; sb = 1; len = 2; fw = 1; end
      4:  rw = 1;
      5:  begin sa = 1; sb = 1; len = 1; end
      6:  begin mreq = 1; adr = 1; end
      7:  begin rw = 1; res = 1; end
      8:  begin mreq = 1; adr = 1; mw = 1; end
      9:  begin sb = 1; len = 3; res = 2;
                pc = (c == 0) ? 1'b1 : (c == 1) ? z : (c == 2) ? !z : n; end
      10: hl = 1;
      11: il = 1;
      default: ;
    endcase
    if (rst) return '0;
    return {pc, ir, adr, mreq, mw, rw, sa, sb, ctl, res, len, fw, hl, il, ret, 4'(ph)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #3;
    chk("cycle_vs_model", {1'b0, dvec},
        {1'b0, expect_out(m_ph, m_op, m_cond, z_flag, n_flag, mem_ready, reset, m_ret)});
  end

  // One clock cycle: inputs change at edge+2, caller's checks run at edge+4.
  task automatic cyc(input logic r, input logic [3:0] o, input logic [1:0] c,
                     input logic z, input logic n, input logic mr);
    @(posedge clk);
    #2;
    reset = r; op = o; cond = c; z_flag = z; n_flag = n; mem_ready = mr;
    #2;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 1);
    chk("reset_all_zero", {1'b0, dvec}, 32'd0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("reset_ir_write", ir_write, 0);
    // ADD
    cyc(0, 0, 0, 0, 0, 1);
    chk("fetch_state", state_dbg, 0);
    chk("fetch_ir_pc", {ir_write, pc_write}, 2'b11);
    cyc(0, 0, 0, 0, 0, 1); chk("decode_state", state_dbg, 1);
    cyc(0, 0, 0, 0, 0, 1); chk("exec_r_state", state_dbg, 2); chk("exec_r_ctrl", alu_ctrl, 0);
    chk("exec_r_regw", reg_write, 0);
    cyc(0, 0, 0, 0, 0, 1); chk("wb_alu_state", state_dbg, 4); chk("wb_alu_regw", reg_write, 1);
    // LDR with a 3-cycle stall
    cyc(0, 5, 0, 0, 0, 1); chk("add_retired", retired, 1); chk("fetch_after_add", state_dbg, 0);
    cyc(0, 5, 0, 0, 0, 1);
    cyc(0, 5, 0, 0, 0, 1); chk("mem_addr_len", len_sel, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 5, 0, 0, 0, 0); chk("mem_rd_hold", state_dbg, 6);
    end
    cyc(0, 5, 0, 0, 0, 1); chk("mem_rd_last", state_dbg, 6);
    cyc(0, 7, 1, 0, 0, 1); chk("wb_mem_res", result_src, 1);
    // B cond=01, not taken then taken
    cyc(0, 7, 1, 0, 0, 1); chk("ldr_retired", retired, 2);
    cyc(0, 7, 1, 0, 0, 1);
    cyc(0, 7, 1, 0, 0, 1); chk("br_len", len_sel, 3); chk("br_not_taken", pc_write, 0);
    cyc(0, 7, 1, 1, 0, 1); chk("br1_retired", retired, 3);
    cyc(0, 7, 1, 1, 0, 1);
    cyc(0, 7, 1, 1, 0, 1); chk("br_taken", pc_write, 1);
    // Illegal opcode trap
    cyc(0, 12, 0, 0, 0, 1); chk("br2_retired", retired, 4);
    cyc(0, 12, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 12, 0, 0, 0, 1);
      chk("illegal_sticky", illegal, 1); chk("illegal_retired", retired, 4);
    end
    cyc(1, 12, 0, 0, 0, 1); chk("illegal_in_reset", illegal, 0);
    // STR aborted by reset during the write wait
    cyc(0, 6, 0, 0, 0, 1); chk("post_reset_state", {illegal, state_dbg}, 0);
    cyc(0, 6, 0, 0, 0, 1);
    cyc(0, 6, 0, 0, 0, 0);
    cyc(0, 6, 0, 0, 0, 0); chk("mem_wr_strobe", mem_write, 1);
    cyc(1, 6, 0, 0, 0, 0); chk("mem_wr_reset", mem_write, 0);
    cyc(0, 4, 0, 0, 0, 1); chk("str_abort_state", state_dbg, 0); chk("str_abort_ret", retired, 0);
    // 256 ADDIs: retired wraps
    for (int k = 0; k < 256; k++) begin
      if (k > 0) cyc(0, 4, 0, 0, 0, 1);
      if (k == 255) chk("retired_255", retired, 255);
      cyc(0, 4, 0, 0, 0, 1);
      cyc(0, 4, 0, 0, 0, 1);
      if (k == 0) chk("exec_i_len", len_sel, 2);
      cyc(0, 4, 0, 0, 0, 1);
    end
    cyc(0, 0, 0, 0, 0, 1); chk("retired_wrap", retired, 0);
    // Random traffic, the per-cycle model comparison does the checking
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] o;
      o = ($urandom_range(0, 15) < 2) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      cyc(($urandom_range(0, 49) == 0), o, 2'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) < 7));
    end
    @(posedge clk); #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Moore-style multi-cycle control unit for the 8-bit processor datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction, and drives every datapath enable and mux select.
- Drives len_sel on the immediate extend unit, choosing the immediate field width per opcode.
- Waits on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 8, width of retired-instruction counter
OP_W, 4, opcode width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  OP_W  opcode field from instruction register
cond  in  2  branch condition field from instruction register
z_flag  in  1  zero flag from flag register
n_flag  in  1  negative flag from flag register
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  PC load enable
ir_write  out  1  instruction register load enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
mem_req  out  1  memory access request
mem_write  out  1  memory write strobe
reg_write  out  1  register file write enable
alu_src_a  out  2  00 PC, 01 reg A, 10 zero
alu_src_b  out  2  00 reg B, 01 extended immediate, 10 constant 1
alu_ctrl  out  2  00 add, 01 sub, 10 and, 11 or
result_src  out  2  00 ALU result register, 01 memory data, 10 ALU output
len_sel  out  2  extend field select: 00 none, 01 imm4 signed, 10 imm5 signed, 11 imm8 pass
flag_write  out  1  flag register load enable
halted  out  1  HALT reached, sticky
illegal  out  1  undefined opcode seen, sticky
retired  out  CNT_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - A synchronous reset sets state = FETCH and clears retired, the latched opcode and the latched condition.
  - While reset is high, every output is 0. This holds even though FETCH would otherwise decode to ir_write = 1.
- Outputs are decoded from the current state and the latched opcode. There is no input-to-output combinational path, except in FETCH and BRANCH as listed below.
- Opcode decode (op):
  - 0 ADD, 1 SUB, 2 AND, 3 ORR
  - 4 ADDI (imm5)
  - 5 LDR (imm4 offset)
  - 6 STR (imm4 offset)
  - 7 B (imm8)
  - 8 HALT
  - 9–15 illegal
- States (state_dbg encoding):
  - FETCH(0): mem_req = 1, adr_src = 0.
    - While mem_ready = 0, stay in FETCH with all writes 0.
    - When mem_ready = 1: ir_write = 1, pc_write = 1, alu_src_a = 00, alu_src_b = 10, alu_ctrl = add, result_src = 10; next state is DECODE.
  - DECODE(1): latch op and cond.
    - R-type → EXEC_R.
    - ADDI → EXEC_I.
    - LDR/STR → MEM_ADDR.
    - B → BRANCH.
    - HALT → HALT.
    - Otherwise → ILLEGAL.
  - EXEC_R(2): alu_src_a = 01, alu_src_b = 00, alu_ctrl = op[1:0], flag_write = 1; → WB_ALU.
  - EXEC_I(3): alu_src_a = 01, alu_src_b = 01, len_sel = 10, alu_ctrl = add, flag_write = 1; → WB_ALU.
  - WB_ALU(4): reg_write = 1, result_src = 00; → FETCH; retired increments.
  - MEM_ADDR(5): alu_src_a = 01, alu_src_b = 01, len_sel = 01, alu_ctrl = add; → MEM_RD if LDR, else MEM_WR.
  - MEM_RD(6): mem_req = 1, adr_src = 1; hold until mem_ready = 1, then → WB_MEM.
  - WB_MEM(7): reg_write = 1, result_src = 01; → FETCH; retired increments.
  - MEM_WR(8): mem_req = 1, adr_src = 1, mem_write = 1 on every cycle in this state; hold until mem_ready = 1, then → FETCH; retired increments.
  - BRANCH(9): alu_src_a = 00, alu_src_b = 01, len_sel = 11, alu_ctrl = add, result_src = 10.
    - pc_write = taken, where taken is: cond 00 always; 01 z_flag; 10 !z_flag; 11 n_flag.
    - → FETCH; retired increments whether or not the branch is taken.
  - HALT(10): halted = 1, all enables 0; stays in HALT until reset.
  - ILLEGAL(11): illegal = 1, all enables 0; stays in ILLEGAL until reset; retired does not increment.
- Outputs not listed for a state are 0 in that state.
- len_sel is 00 outside EXEC_I, MEM_ADDR and BRANCH.
- retired wraps modulo 2^CNT_W.
- A reset asserted mid-instruction (including during a mem_ready wait) aborts the instruction. The aborted instruction does not count as retired, and no write enable is asserted in the reset cycle.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.

Test Plan:
- Reset for 2 cycles, then release with mem_ready = 1 → state_dbg = 0, ir_write = 1, pc_write = 1; all outputs were 0 during reset.
- ADD (op = 0), mem_ready = 1 → states 0, 1, 2, 4, back to 0 over 4 cycles; alu_ctrl = 00 in EXEC_R; reg_write = 1 in WB_ALU only; retired goes 0 → 1.
- LDR (op = 5) with mem_ready low for 3 cycles in MEM_RD → len_sel = 01 in MEM_ADDR; MEM_RD held 4 cycles; WB_MEM result_src = 01; retired increments once.
- B (op = 7):
  - cond = 01 with z_flag = 0 → len_sel = 11, pc_write = 0.
  - Repeat with z_flag = 1 → pc_write = 1.
- op = 12 → illegal = 1, held for 10 cycles; retired unchanged. Then reset → illegal = 0, state_dbg = 0.
- STR (op = 6) with reset asserted during a MEM_WR wait → mem_write = 0 in the reset cycle; retired unchanged; FETCH on release.
- 256 ADDIs with CNT_W = 8 → retired wraps from 255 to 0.
